alu_result_tx_framer: RTL

- Downstream of the ALU (arithmetic, logic, compare and shift units).
- Captures each new ALU result, marked by a rising edge on the ALU valid flag, into a small FIFO.
- Splits each result into bytes and hands the bytes one at a time to the UART TX block.
- Decouples ALU result bursts from the slow serial link; same clock domain as the ALU. Any CDC to the UART clock is handled outside this block.

---
 rtl/alu_result_tx_framer_pkg.sv | 19 +
 rtl/alu_result_fifo.sv | 51 +++++
 rtl/alu_result_tx_framer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_result_tx_framer_pkg.sv
// Shared definitions for the ALU result TX framer: FSM state encoding, byte width
// and the FIFO pointer-width helper.
package alu_result_tx_framer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD    = 2'b01,
    WAIT_HI = 2'b10,
    WAIT_LO = 2'b11
  } tx_state_e;

  localparam int BYTE_W = 8;

  // One extra bit beyond the address distinguishes full from empty.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous FIFO for captured ALU results. A push while full is dropped, even if a
// pop happens in the same cycle.
module alu_result_fifo
  import alu_result_tx_framer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = wr_ptr_q + PW'(do_push);
  assign rd_ptr_d = rd_ptr_q + PW'(do_pop);
  assign data_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/alu_result_tx_framer.sv
// Buffers ALU results (one per ALU_VALID rising edge) and feeds them bytewise to the UART TX.
// Byte order is LSB first; define ALU_TX_MSB_FIRST_EN for MSB first.
//   state   | meaning
//   IDLE    | pop next result into shift register when FIFO not empty
//   LOAD    | strobe current byte as soon as TX is not busy
//   WAIT_HI | wait for TX to acknowledge by raising busy
//   WAIT_LO | wait for TX done; next byte or back to IDLE
module alu_result_tx_framer
  import alu_result_tx_framer_pkg::*;
#(
  parameter int Width      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [Width-1:0]  ALU_OUT,
  input  logic              ALU_VALID,
  input  logic              TX_BUSY,
  output logic [BYTE_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  output logic              FIFO_FULL,
  output logic              OVERFLOW
);

  localparam int NBYTES = Width / BYTE_W;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  tx_state_e         state_q, state_d;
  logic              valid_q;
  logic              push, pop;
  logic [Width-1:0]  fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [Width-1:0]  shreg_q, shreg_d, shreg_next;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d, cur_byte;
  logic              tx_vld_q, tx_vld_d;
  logic              ovf_q, ovf_d;

  assign push  = ALU_VALID && !valid_q;
  assign ovf_d = ovf_q | (push && fifo_full);

  alu_result_fifo #(.WIDTH(Width), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push),
    .data_i  (ALU_OUT),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef ALU_TX_MSB_FIRST_EN
  assign cur_byte   = shreg_q[Width-1 -: BYTE_W];
  assign shreg_next = shreg_q << BYTE_W;
`else
  assign cur_byte   = shreg_q[BYTE_W-1:0];
  assign shreg_next = shreg_q >> BYTE_W;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      shreg_q   <= '0;
      idx_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= ALU_VALID;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = LOAD;
      LOAD:    if (!TX_BUSY) state_d = WAIT_HI;
      WAIT_HI: if (TX_BUSY) state_d = WAIT_LO;
      WAIT_LO: if (!TX_BUSY) state_d = (idx_q == LAST_IDX) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        shreg_d = fifo_dout;
        idx_d   = '0;
      end
      LOAD: if (!TX_BUSY) begin
        tx_vld_d  = 1'b1;
        tx_data_d = cur_byte;
      end
      WAIT_LO: if (!TX_BUSY && idx_q != LAST_IDX) begin
        idx_d   = idx_q + IW'(1);
        shreg_d = shreg_next;
      end
      default: ;
    endcase
  end

  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign FIFO_FULL = fifo_full;
  assign OVERFLOW  = ovf_q;

endmodule
